execute_sched: RTL
==================

// Module: execute_sched
// PURPOSE
//  In-order, single-issue scheduler between decode/regfile-read and the multi-cycle execute units
//  (execute_shift and siblings). Routes one issued instruction to its selected unit and holds
//  further issue while that unit is processing. Registers the unit's result for writeback.
//  Reports illegal ops and watchdog timeouts.
// PARAMETERS
//  NUM_UNITS  4    number of execute units attached (index 0..NUM_UNITS-1)
//  TIMEOUT    64   max BUSY cycles before watchdog abort (>=2)
// PORTS
//  clk            in   1            clock, all state on posedge
//  reset          in   1            synchronous, active-low (0 = reset)
//  flush          in   1            pipeline flush; also forwarded to units
//  issue_valid    in   1            decoded instr + operands valid this cycle
//  issue_unit     in   $clog2(NUM_UNITS)+1  target unit index
//  issue_rd       in   5            destination register index
//  issue_ready    out  1            scheduler can accept issue this cycle
//  unit_flush     out  1            = flush (combinational)
//  unit_read_valid out NUM_UNITS    one-hot read_valid to selected unit
//  unit_processing in  NUM_UNITS    per-unit processing
//  unit_valid     in   NUM_UNITS    per-unit result valid
//  unit_rd_val    in   32*NUM_UNITS per-unit result, unit i at [32*i+:32]
//  wb_valid       out  1            writeback strobe (1-cycle pulse)
//  wb_rd          out  5            writeback register index
//  wb_rd_val      out  32           writeback value
//  illegal_op     out  1            1-cycle pulse: issue rejected
//  timeout_err    out  1            1-cycle pulse: watchdog expired
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, cur_unit=0, cur_rd=0, count=0. wb_valid, wb_rd,
//   wb_rd_val, illegal_op and timeout_err are all 0. Reset overrides flush and all inputs.
//  Combinational outputs: issue_ready = (state==IDLE) && !flush.
//   unit_read_valid[i] = issue_valid && issue_ready && issue_unit==i. This is zero for an out-of-range unit.
//  FSM IDLE, on accepted issue (issue_valid && issue_ready):
//   - issue_unit >= NUM_UNITS, or unit_processing[sel]==0: illegal_op=1 next cycle; stay IDLE.
//   - unit_valid[sel]==1 same cycle: register the result for writeback; stay IDLE.
//     Latency is 1 cycle.
//   - otherwise: latch cur_unit=sel and cur_rd=issue_rd, set count=1, go to BUSY.
//  FSM BUSY: issue_ready=0 and unit_read_valid=0. Each cycle count++.
//   - unit_valid[cur_unit]==1: register the result from unit_rd_val[cur_unit]; go to IDLE.
//   - else if count==TIMEOUT-1: timeout_err=1 next cycle; go to IDLE; no writeback.
//  unit_valid or unit_rd_val from a non-selected unit is always ignored.
//  Result register: wb_valid <= result_taken && (rd!=0). wb_rd and wb_rd_val are loaded only when
//   result_taken; otherwise they hold. rd==0 results are dropped without a wb_valid pulse.
//  flush: in any state, flush==1 forces next state=IDLE and count=0, and suppresses wb_valid,
//   illegal_op and timeout_err for the result/error of that same cycle. No issue is accepted in a
//   flush cycle. A wb_valid already registered (pulse in the flush cycle) is not retracted.
//  Issue is accepted only in IDLE. Back-to-back single-cycle ops sustain 1 issue/cycle.
//   The cycle a BUSY op completes is not an issue cycle; the next issue is accepted the cycle after.
//  count width is $clog2(TIMEOUT)+1. count never wraps because the watchdog fires first.
// TESTING
//  1. Reset low 2 cycles -> all outputs 0, issue_ready=0 while reset asserted, =1 after release
//     with flush=0.
//  2. Issue unit0 (1-cycle), rd=5, unit_valid[0]=1 val=0x12345678 same cycle ->
//     wb_valid=1, wb_rd=5, wb_rd_val=0x12345678 on the next cycle; issue_ready stays 1.
//  3. Issue shift unit SRLI by 20 on 0x80000000, rd=3 -> BUSY 2 cycles, issue_ready=0;
//     wb_valid with wb_rd_val=0x00000800 on the 3rd cycle after issue. A second issue during
//     BUSY produces no read_valid.
//  4. Issue to unit 1 with unit_processing[1]=0 -> illegal_op pulse, no wb_valid.
//     Issue_unit=NUM_UNITS -> illegal_op pulse, unit_read_valid=0.
//  5. Multi-cycle op, flush asserted the same cycle as unit_valid -> no wb_valid, state IDLE,
//     unit_flush=1. Next issue accepted cycle after.
//  6. TIMEOUT=8, unit never returns valid -> timeout_err exactly 8 cycles after issue, then
//     issue_ready=1. Also: rd=0 result -> no wb_valid.

Source files
------------

// File: rtl/execute_sched.sv
// In-order single-issue scheduler: routes one instruction to an execute unit, holds issue while
// that unit is busy, registers its result for writeback and flags illegal ops / watchdog expiry.
module execute_sched #(
    parameter int NUM_UNITS = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            issue_valid,
    input  logic [$clog2(NUM_UNITS):0]      issue_unit,
    input  logic [4:0]                      issue_rd,
    output logic                            issue_ready,
    output logic                            unit_flush,
    output logic [NUM_UNITS-1:0]            unit_read_valid,
    input  logic [NUM_UNITS-1:0]            unit_processing,
    input  logic [NUM_UNITS-1:0]            unit_valid,
    input  logic [32*NUM_UNITS-1:0]         unit_rd_val,
    output logic                            wb_valid,
    output logic [4:0]                      wb_rd,
    output logic [31:0]                     wb_rd_val,
    output logic                            illegal_op,
    output logic                            timeout_err
);
    localparam int UW = $clog2(NUM_UNITS) + 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t          r_state;
    logic [UW-1:0]   r_cur_unit;
    logic [4:0]      r_cur_rd;
    logic [CW-1:0]   r_count;

    logic            w_accept;
    logic            w_sel_proc;
    logic            w_sel_valid;
    logic [31:0]     w_sel_val;
    logic            w_cur_valid;
    logic [31:0]     w_cur_val;
    logic            w_take;
    logic [4:0]      w_take_rd;
    logic [31:0]     w_take_val;
    logic            w_illegal;
    logic            w_timeout;
    logic            w_go_busy;

    assign issue_ready = reset && (r_state == S_IDLE) && !flush;
    assign unit_flush  = flush;
    assign w_accept    = issue_valid && issue_ready;

    // An out-of-range issue_unit matches no slot, so it reads as "not processing" and is illegal.
    always_comb begin
        w_sel_proc      = 1'b0;
        w_sel_valid     = 1'b0;
        w_sel_val       = '0;
        w_cur_valid     = 1'b0;
        w_cur_val       = '0;
        unit_read_valid = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (issue_unit == UW'(i)) begin
                w_sel_proc         = unit_processing[i];
                w_sel_valid        = unit_valid[i];
                w_sel_val          = unit_rd_val[32*i +: 32];
                unit_read_valid[i] = w_accept;
            end
            if (r_cur_unit == UW'(i)) begin
                w_cur_valid = unit_valid[i];
                w_cur_val   = unit_rd_val[32*i +: 32];
            end
        end
    end

    always_comb begin
        w_take     = 1'b0;
        w_take_rd  = r_cur_rd;
        w_take_val = w_cur_val;
        w_illegal  = 1'b0;
        w_timeout  = 1'b0;
        w_go_busy  = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_accept) begin
                if (!w_sel_proc) begin
                    w_illegal = 1'b1;
                end else if (w_sel_valid) begin
                    w_take     = 1'b1;
                    w_take_rd  = issue_rd;
                    w_take_val = w_sel_val;
                end else begin
                    w_go_busy = 1'b1;
                end
            end
        end else begin
            if (w_cur_valid) begin
                w_take = 1'b1;
            end else if (r_count == CW'(TIMEOUT - 1)) begin
                w_timeout = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cur_unit  <= '0;
            r_cur_rd    <= '0;
            r_count     <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_rd_val   <= '0;
            illegal_op  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            wb_valid    <= w_take && !flush && (w_take_rd != 5'd0);
            illegal_op  <= w_illegal && !flush;
            timeout_err <= w_timeout && !flush;
            if (w_take && !flush) begin
                wb_rd     <= w_take_rd;
                wb_rd_val <= w_take_val;
            end
            if (flush) begin
                r_state <= S_IDLE;
                r_count <= '0;
            end else if (r_state == S_IDLE) begin
                if (w_go_busy) begin
                    r_state    <= S_BUSY;
                    r_cur_unit <= issue_unit;
                    r_cur_rd   <= issue_rd;
                    r_count    <= CW'(1);
                end
            end else if (w_take || w_timeout) begin
                r_state <= S_IDLE;
                r_count <= '0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end
endmodule
